// File: rtl/sram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared definitions for the asynchronous SRAM controller slice:
//   - state_t      : controller FSM state enumeration
//   - CNT_W        : width of the per-beat wait counter (covers WAIT_CYC 0..7)
//   - WAIT_MAX     : largest supported WAIT_CYC value
//   - beat_cycles(): number of clock cycles one SRAM beat occupies
// ---------------------------------------------------------------------------
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD      = 2'd1,
        ST_WR      = 2'd2,
        ST_WR_HOLD = 2'd3
    } state_t;

    localparam int unsigned CNT_W    = 3;
    localparam int unsigned WAIT_MAX = 7;

    // One beat is the base access cycle plus the configured wait cycles.
    function automatic int unsigned beat_cycles(input int unsigned wait_cyc);
        return wait_cyc + 1;
    endfunction

endpackage

// File: rtl/sram_ctrl_gen_if.sv
// ---------------------------------------------------------------------------
// sram_ctrl_gen_if
// Request/response bus between a host and the SRAM controller.
//   req_valid/req_ready : request handshake (accepted when both are 1)
//   req_we              : 1 = write, 0 = read
//   req_addr            : start word address
//   req_len             : read beats minus one (burst builds only)
//   req_wdata           : write data
//   rsp_valid           : one-cycle read data strobe
//   rsp_rdata           : registered read data
//   rsp_last            : final beat of a read
// Modports: master (host side), slave (controller side).
// ---------------------------------------------------------------------------
interface sram_ctrl_gen_if #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DATA_W = 9,
    parameter int unsigned LEN_W  = 4
);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_last;

    modport master (
        output req_valid, req_we, req_addr, req_len, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_last
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_len, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_last
    );

endinterface

// File: rtl/sram_beat_timer.sv
// ---------------------------------------------------------------------------
// sram_beat_timer
// Down-counter that times one SRAM beat. A start pulse (asserted in the
// cycle before the beat begins) loads WAIT_CYC; the counter then runs down
// to zero and 'last' marks the final cycle of the beat.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   start : load the counter for a new beat at the next edge
//   last  : current cycle is the last cycle of the beat
// ---------------------------------------------------------------------------
module sram_beat_timer
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic last
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(beat_cycles(WAIT_CYC) - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= LOAD_VAL;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign last = (cnt == '0);

endmodule

// File: rtl/sram_ctrl_gen.sv
// ---------------------------------------------------------------------------
// sram_ctrl_gen
// Controller for an asynchronous SRAM. Accepts single reads/writes (and
// incrementing read bursts when SRAM_CTRL_BURST_EN is defined) from a
// valid/ready host bus and sequences the SRAM strobes.
//
// Ports:
//   clk        : rising-edge clock
//   reset      : synchronous active-high reset
//   host       : sram_ctrl_gen_if.slave request/response bus
//   sram_addr  : registered SRAM word address
//   sram_ce_n  : chip enable, tied active
//   sram_oe_n  : registered output enable, active low
//   sram_we_n  : registered write enable, active low
//   sram_dq    : bidirectional SRAM data bus (driven only in WR/WR_HOLD)
//
// Build option:
//   SRAM_CTRL_BURST_EN : when defined, a read performs req_len+1 beats at
//                        incrementing (wrapping) addresses; otherwise
//                        req_len is ignored. Writes are always single-beat.
// ---------------------------------------------------------------------------
module sram_ctrl_gen
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W   = 19,
    parameter int unsigned DATA_W   = 9,
    parameter int unsigned WAIT_CYC = 1,
    parameter int unsigned LEN_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    sram_ctrl_gen_if.slave    host,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    inout  wire  [DATA_W-1:0] sram_dq
);

    state_t            state;
    state_t            state_nxt;

    logic              accept;
    logic              timer_start;
    logic              beat_last;
    logic              more_beats;
    logic [LEN_W-1:0]  req_len_eff;
    logic [LEN_W-1:0]  beats_left;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              oe_n_q;
    logic              we_n_q;
    logic              dq_oe;

    logic              rsp_valid_q;
    logic              rsp_last_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    // -----------------------------------------------------------------------
    // Burst length selection
    // -----------------------------------------------------------------------
`ifdef SRAM_CTRL_BURST_EN
    assign req_len_eff = host.req_len;
`else
    logic unused_req_len;
    assign unused_req_len = ^host.req_len;
    assign req_len_eff    = '0;
`endif

    assign host.req_ready = (state == ST_IDLE);
    assign accept         = host.req_valid && (state == ST_IDLE);
    assign more_beats     = (beats_left != '0);

    // -----------------------------------------------------------------------
    // Beat timer
    // -----------------------------------------------------------------------
    sram_beat_timer #(
        .WAIT_CYC (WAIT_CYC)
    ) u_beat_timer (
        .clk   (clk),
        .reset (reset),
        .start (timer_start),
        .last  (beat_last)
    );

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and timer control
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        timer_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (host.req_valid) begin
                    state_nxt   = host.req_we ? ST_WR : ST_RD;
                    timer_start = 1'b1;
                end
            end
            ST_RD: begin
                if (beat_last) begin
                    // A continuing burst stays in RD and reloads the timer,
                    // so the output enable never deasserts between beats.
                    if (more_beats) begin
                        timer_start = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_WR: begin
                if (beat_last) begin
                    state_nxt = ST_WR_HOLD;
                end
            end
            ST_WR_HOLD: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registered SRAM strobes, address, write data and read response.
    // Strobes decode state_nxt so the pins change cleanly on the same edge
    // as the state register.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            beats_left  <= '0;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            oe_n_q      <= (state_nxt != ST_RD);
            we_n_q      <= (state_nxt != ST_WR);
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;

            if (accept) begin
                addr_q     <= host.req_addr;
                wdata_q    <= host.req_wdata;
                beats_left <= host.req_we ? '0 : req_len_eff;
            end

            if ((state == ST_RD) && beat_last) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= sram_dq;
                rsp_last_q  <= !more_beats;
                if (more_beats) begin
                    // Natural overflow gives the wrap from all-ones to zero.
                    addr_q     <= addr_q + 1'b1;
                    beats_left <= beats_left - 1'b1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Pin drive
    // -----------------------------------------------------------------------
    assign dq_oe     = (state == ST_WR) || (state == ST_WR_HOLD);
    assign sram_dq   = dq_oe ? wdata_q : 'z;

    assign sram_addr = addr_q;
    assign sram_ce_n = 1'b0;
    assign sram_oe_n = oe_n_q;
    assign sram_we_n = we_n_q;

    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_last  = rsp_last_q;
    assign host.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_sram_ctrl_gen.sv
// ---------------------------------------------------------------------------
// tb_sram_ctrl_gen
// Self-checking bench for sram_ctrl_gen. An SRAM model sits on the pins and
// a reference memory predicts read data; expected strobe timing is computed
// from beat arithmetic (beats * (WAIT_CYC+1) cycles per access).
// Honours SRAM_CTRL_BURST_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_sram_ctrl_gen;

    localparam int unsigned ADDR_W   = 19;
    localparam int unsigned DATA_W   = 9;
    localparam int unsigned WAIT_CYC = 1;
    localparam int unsigned LEN_W    = 4;
    localparam int unsigned BEAT     = WAIT_CYC + 1;
    localparam int unsigned AMASK    = (1 << ADDR_W) - 1;
`ifdef SRAM_CTRL_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sram_ctrl_gen_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    logic [ADDR_W-1:0] sram_addr;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;
    wire  [DATA_W-1:0] sram_dq;

    sram_ctrl_gen #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .WAIT_CYC (WAIT_CYC),
        .LEN_W    (LEN_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .host      (bus),
        .sram_addr (sram_addr),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n),
        .sram_dq   (sram_dq)
    );

    // SRAM model: drives the bus while output-enabled, stores on write strobe.
    logic [DATA_W-1:0] mem     [int unsigned];
    logic [DATA_W-1:0] ref_mem [int unsigned];
    logic [DATA_W-1:0] rd_drive;

    function automatic logic [DATA_W-1:0] dflt(input int unsigned a);
        return DATA_W'(a * 37 + 5);
    endfunction

    function automatic logic [DATA_W-1:0] ref_rd(input int unsigned a);
        int unsigned m;
        m = a & AMASK;
        return ref_mem.exists(m) ? ref_mem[m] : dflt(m);
    endfunction

    assign sram_dq = (!sram_oe_n && sram_we_n) ? rd_drive : 'z;

    always @(negedge clk) begin
        rd_drive = mem.exists(int'(sram_addr)) ? mem[int'(sram_addr)] : dflt(int'(sram_addr));
    end

    always @(posedge clk) begin
        if (!sram_we_n) mem[int'(sram_addr)] = sram_dq;
    end

    int checks = 0;
    int errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_req();
        bus.req_we    = 1'($urandom);
        bus.req_addr  = ADDR_W'($urandom);
        bus.req_len   = LEN_W'($urandom);
        bus.req_wdata = DATA_W'($urandom);
    endtask

    // Runs one access and checks every cycle of it against beat arithmetic.
    task automatic txn(input bit we, input int unsigned addr, input int unsigned len,
                       input logic [DATA_W-1:0] wd, input string tag);
        int unsigned beats, act, last_k, waited, b, j;
        logic [4:0] exp_v, obs_v;
        logic [ADDR_W-1:0] exp_a;
        beats = we ? 1 : (BURST ? len + 1 : 1);
        act   = beats * BEAT;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = ADDR_W'(addr);
        bus.req_len   = LEN_W'(len);
        bus.req_wdata = wd;
        waited = 0;
        while (bus.req_ready !== 1'b1 && waited < 50) begin
            step();
            waited++;
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept_timeout: req_ready=%b want 1", tag, bus.req_ready);
            bus.req_valid = 1'b0;
            return;
        end
        step();
        bus.req_valid = 1'b0;
        scramble_req();
        last_k = we ? BEAT + 2 : act + 1;
        for (int unsigned k = 1; k <= last_k; k++) begin
            if (k > 1) step();
            obs_v = {sram_oe_n, sram_we_n, bus.req_ready, bus.rsp_valid, dut.dq_oe};
            if (we) begin
                exp_v = {1'b1, (k <= BEAT) ? 1'b0 : 1'b1, (k > BEAT + 1), 1'b0, (k <= BEAT + 1)};
                exp_a = ADDR_W'(addr);
            end else begin
                b = (k <= act) ? (k - 1) / BEAT : beats - 1;
                exp_v = {(k <= act) ? 1'b0 : 1'b1, 1'b1, (k > act), (k > 1) && ((k - 1) % BEAT == 0), 1'b0};
                exp_a = ADDR_W'((addr + b) & AMASK);
            end
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL %s strobes k=%0d {oe_n,we_n,ready,rsp_valid,dq_oe}: got %b want %b",
                         tag, k, obs_v, exp_v);
            end
            checks++;
            if (sram_addr !== exp_a) begin
                errors++;
                $display("FAIL %s addr k=%0d: got %h want %h", tag, k, sram_addr, exp_a);
            end
            if (we && k <= BEAT + 1) begin
                checks++;
                if (sram_dq !== wd) begin
                    errors++;
                    $display("FAIL %s wdata k=%0d: got %h want %h", tag, k, sram_dq, wd);
                end
            end
            if (!we && exp_v[1]) begin
                j = (k - 1) / BEAT;
                checks++;
                if ({bus.rsp_rdata, bus.rsp_last} !== {ref_rd(addr + j - 1), (j == beats)}) begin
                    errors++;
                    $display("FAIL %s rsp beat=%0d {rdata,last}: got %h/%b want %h/%b", tag, j,
                             bus.rsp_rdata, bus.rsp_last, ref_rd(addr + j - 1), (j == beats));
                end
            end
        end
        if (we) ref_mem[addr & AMASK] = wd;
    endtask

    task automatic test_reset();
        logic [4:0] obs_v;
        reset = 1'b1;
        bus.req_valid = 1'b1;
        scramble_req();
        step();
        step();
        reset = 1'b0;
        bus.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            obs_v = {sram_oe_n, sram_we_n, bus.req_ready, bus.rsp_valid, dut.dq_oe};
            checks++;
            if (obs_v !== 5'b11100) begin
                errors++;
                $display("FAIL reset_strobes i=%0d {oe_n,we_n,ready,rsp_valid,dq_oe}: got %b want 11100", i, obs_v);
            end
            checks++;
            if ({bus.rsp_last, bus.rsp_rdata, sram_addr, sram_ce_n} !== '0) begin
                errors++;
                $display("FAIL reset_values i=%0d: last=%b rdata=%h addr=%h ce_n=%b want all 0",
                         i, bus.rsp_last, bus.rsp_rdata, sram_addr, sram_ce_n);
            end
        end
    endtask

    task automatic test_read();
        mem[32'h10]     = 9'h0F3;
        ref_mem[32'h10] = 9'h0F3;
        txn(1'b0, 32'h10, 0, '0, "single_read");
    endtask

    task automatic test_write();
        txn(1'b1, 32'h10, 0, 9'h1A5, "single_write");
        checks++;
        if (mem[32'h10] !== 9'h1A5) begin
            errors++;
            $display("FAIL write_stored: got %h want 1a5", mem[32'h10]);
        end
        txn(1'b0, 32'h10, 0, '0, "read_after_write");
    endtask

    task automatic test_burst_wrap();
        txn(1'b0, 32'h7FFFE, 3, '0, "burst_wrap");
    endtask

    task automatic test_back_to_back();
        int unsigned k, n;
        logic [DATA_W-1:0] d;
        d = DATA_W'($urandom);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = ADDR_W'(32'h55);
        bus.req_len   = '0;
        bus.req_wdata = d;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_start_ready: got %b want 1", bus.req_ready);
        end
        step();
        bus.req_we = 1'b0;
        k = 1;
        while (bus.req_ready !== 1'b1 && k < 20) begin
            checks++;
            if (sram_oe_n !== 1'b1) begin
                errors++;
                $display("FAIL b2b_early_read k=%0d: oe_n=%b we_n=%b want oe_n 1", k, sram_oe_n, sram_we_n);
            end
            step();
            k++;
        end
        checks++;
        if (k !== BEAT + 2) begin
            errors++;
            $display("FAIL b2b_read_accept_cycle: got %0d want %0d", k, BEAT + 2);
        end
        step();
        bus.req_valid = 1'b0;
        n = 1;
        while (bus.rsp_valid !== 1'b1 && n < 20) begin
            checks++;
            if (!sram_oe_n && !sram_we_n) begin
                errors++;
                $display("FAIL b2b_overlap n=%0d: oe_n=%b we_n=%b want not both 0", n, sram_oe_n, sram_we_n);
            end
            step();
            n++;
        end
        checks++;
        if ({n, bus.rsp_rdata, bus.rsp_last} !== {BEAT + 1, d, 1'b1}) begin
            errors++;
            $display("FAIL b2b_read: latency=%0d rdata=%h last=%b want %0d/%h/1",
                     n, bus.rsp_rdata, bus.rsp_last, BEAT + 1, d);
        end
        ref_mem[32'h55] = d;
        step();
    endtask

    task automatic test_random();
        bit we;
        int unsigned a;
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 1));
            a  = $urandom_range(0, 1) ? 32'h10 + $urandom_range(0, 7) : 32'h7FFF8 + $urandom_range(0, 7);
            txn(we, a, $urandom_range(0, 15), DATA_W'($urandom), we ? "rand_write" : "rand_read");
        end
    endtask

    task automatic test_mid_reset();
        int unsigned rc;
        logic [4:0] obs_v;
        rc = BURST ? BEAT + 1 : 1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = ADDR_W'(32'h200);
        bus.req_len   = LEN_W'(7);
        step();
        bus.req_valid = 1'b0;
        for (int unsigned k = 1; k < rc; k++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        obs_v = {sram_oe_n, sram_we_n, bus.req_ready, bus.rsp_valid, dut.dq_oe};
        checks++;
        if ({obs_v, bus.rsp_last, bus.rsp_rdata, sram_addr} !== {5'b11100, 1'b0, 9'h0, 19'h0}) begin
            errors++;
            $display("FAIL midrd_reset_idle: strobes=%b last=%b rdata=%h addr=%h want 11100/0/0/0",
                     obs_v, bus.rsp_last, bus.rsp_rdata, sram_addr);
        end
        for (int i = 0; i < 8 * BEAT + 4; i++) begin
            step();
            checks++;
            if ({bus.rsp_valid, sram_oe_n} !== 2'b01) begin
                errors++;
                $display("FAIL midrd_no_strobe i=%0d {rsp_valid,oe_n}: got %b%b want 01", i, bus.rsp_valid, sram_oe_n);
            end
        end
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = ADDR_W'(32'h300);
        bus.req_wdata = DATA_W'($urandom);
        step();
        bus.req_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < BEAT + 3; i++) begin
            if (i > 0) step();
            checks++;
            if ({sram_we_n, dut.dq_oe} !== 2'b10) begin
                errors++;
                $display("FAIL midwr_no_pulse i=%0d {we_n,dq_oe}: got %b%b want 10", i, sram_we_n, dut.dq_oe);
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.req_wdata = '0;
        test_reset();
        test_read();
        test_write();
        test_burst_wrap();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sram_ctrl_gen.md
SRAM_CTRL_GEN -- requirements
Module: sram_ctrl_gen

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter ADDR_W, default 19, SHALL set the SRAM word address width.
REQ-003 Parameter DATA_W, default 9, SHALL set the SRAM data width.
REQ-004 Parameter WAIT_CYC, default 1, range 0..7, SHALL set the extra access cycles per beat; each beat lasts WAIT_CYC+1 cycles.
REQ-005 Parameter LEN_W, default 4, SHALL set the burst length field width.
REQ-006 The ports SHALL be, one per line:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  request offered
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  start word address
- req_len  in  LEN_W  read beats minus one
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle read data strobe
- rsp_rdata  out  DATA_W  registered read data
- rsp_last  out  1  final beat of a burst
- sram_addr  out  ADDR_W  SRAM address
- sram_ce_n  out  1  chip enable, tied 0
- sram_oe_n  out  1  output enable, active low
- sram_we_n  out  1  write enable, active low
- sram_dq  inout  DATA_W  SRAM data bus

Function
REQ-007 A request SHALL be accepted on a cycle T where req_valid and req_ready are both 1; req_ready SHALL be 1 only in IDLE.
REQ-008 The FSM states SHALL be IDLE, RD, WR and WR_HOLD; any other encoding SHALL return to IDLE.
REQ-009 On a read accepted at T, the block SHALL enter RD, drive sram_oe_n = 0 from T+1 for WAIT_CYC+1 cycles, sample sram_dq at the end of the last cycle, and assert rsp_valid with rsp_rdata at T+WAIT_CYC+2.
REQ-010 On a write accepted at T, the block SHALL enter WR and drive sram_we_n = 0 from T+1 for WAIT_CYC+1 cycles.
REQ-011 After WR, the block SHALL spend one WR_HOLD cycle with sram_we_n = 1 while still driving data, then return to IDLE.
REQ-012 sram_dq SHALL be driven with the registered write data only in WR and WR_HOLD, and SHALL be high-Z otherwise.
REQ-013 sram_addr, sram_oe_n and sram_we_n SHALL be registered outputs using look-ahead decode of the next state, so they are glitch-free.
REQ-014 sram_addr, req_wdata and req_len SHALL be captured at acceptance; sram_addr SHALL hold its value in IDLE.
REQ-015 sram_oe_n and sram_we_n SHALL never both be 0 in the same cycle.
REQ-016 Requests arriving outside IDLE SHALL be held off (req_ready = 0) and SHALL NOT be dropped or corrupted.
REQ-017 rsp_last SHALL be 1 together with rsp_valid on a single read and on the final beat of a burst.

Reset
REQ-018 While reset is 1 at a clock edge, the block SHALL set: state IDLE, req_ready 1 on the following cycle, rsp_valid 0, rsp_last 0, rsp_rdata 0, sram_addr 0, sram_oe_n 1, sram_we_n 1, sram_dq high-Z.
REQ-019 A reset in the middle of an access SHALL abort it within one cycle, with no further strobe and no trailing write pulse.

Configuration
REQ-020 With SRAM_CTRL_BURST_EN defined, a read with req_len = N SHALL perform N+1 back-to-back beats.
REQ-021 During a burst, sram_oe_n SHALL stay 0 throughout and sram_addr SHALL increment by 1 every WAIT_CYC+1 cycles, wrapping from 2^ADDR_W-1 to 0.
REQ-022 During a burst, each beat SHALL produce one rsp_valid, and rsp_last SHALL be asserted on beat N+1.
REQ-023 Without SRAM_CTRL_BURST_EN, req_len SHALL be ignored and treated as 0.
REQ-024 Writes SHALL always be single-beat, in both configurations.

Structure
REQ-025 The state enumeration and a WAIT_CYC-based beat-length function SHALL reside in package sram_ctrl_pkg.
REQ-026 A sub-module sram_beat_timer (a down-counter loaded with WAIT_CYC, flagging the last cycle) SHALL time each beat.

Verification
REQ-027 Reset then idle: after reset, req_ready = 1, sram_oe_n = 1, sram_we_n = 1, sram_dq = Z, rsp_valid = 0.
REQ-028 Single write: WAIT_CYC=1, write addr 0x00010 data 0x1A5 accepted at T -> sram_we_n low T+1..T+2, dq = 0x1A5 driven T+1..T+3, req_ready high at T+4.
REQ-029 Single read: SRAM model holds 0x0F3 at addr 0x00010; read accepted at T -> rsp_valid = 1, rsp_rdata = 0x0F3, rsp_last = 1 at T+3.
REQ-030 Burst wrap (macro defined): read addr 0x7FFFE, len 3 -> four strobes for addrs 0x7FFFE, 0x7FFFF, 0x00000, 0x00001, with rsp_last on the fourth.
REQ-031 Back-to-back: req_valid held high for a write then a read to the same address -> read is accepted only after WR_HOLD, returns the written data, and oe_n/we_n never overlap.
REQ-032 Mid-burst reset: reset asserted during beat 2 of a len-7 burst -> next cycle shows IDLE outputs, with no further rsp_valid.
